// File: rtl/fifo_rd_stream_pkg.sv
// Shared types and constants for the FIFO read-side stream engine.
package fifo_rd_stream_pkg;

    localparam int unsigned BUF_DEPTH     = 2;
    localparam int unsigned OCC_WIDTH     = 2;
    localparam int unsigned PKT_IDX_WIDTH = 16;

    typedef logic [OCC_WIDTH-1:0]     occ_t;
    typedef logic [PKT_IDX_WIDTH-1:0] pkt_idx_t;

    // Words buffered plus in flight, after this cycle's pop leaves.
    function automatic logic [2:0] pending(input occ_t occ, input logic infl, input logic pop);
        return 3'(occ) + 3'(infl) - 3'(pop);
    endfunction

endpackage

// File: rtl/fifo_rd_stream_if.sv
// Downstream valid/ready word stream with packet framing.
interface fifo_rd_stream_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_last;

    modport master (output m_valid, output m_data, output m_last, input m_ready);
    modport slave  (input m_valid, input m_data, input m_last, output m_ready);
endinterface

// File: rtl/fifo_rd_stream_skid.sv
// Two-entry output buffer: push at tail, pop from head, occupancy tracking.
module fifo_rd_stream_skid
    import fifo_rd_stream_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output occ_t                  occ,
    output logic [DATA_WIDTH-1:0] head
);

    localparam occ_t OCC_MAX = occ_t'(BUF_DEPTH);

    logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
    logic                  wr_ptr;
    logic                  rd_ptr;

    // Storage and 1-bit pointers; pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
        end
    end

    // Occupancy: simultaneous push and pop cancel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ <= '0;
        end else begin
            case ({push, pop})
                2'b10:   occ <= occ + occ_t'(1);
                2'b01:   occ <= occ - occ_t'(1);
                default: occ <= occ;
            endcase
        end
    end

    assign head = mem[rd_ptr];

    occ_bound: assert property (@(posedge clk) disable iff (!rst_n) occ <= OCC_MAX);

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side drain engine for a single-clock FIFO with one-cycle read latency.
// Issues reads against rd_empty, buffers up to two words, and presents them
// as a framed valid/ready stream (m_last every PKT_LEN beats).
// Optional: define FIFO_RD_STREAM_BEAT_CNT_EN to add the beat_cnt output.
module fifo_rd_stream
    import fifo_rd_stream_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned PKT_LEN    = 16
`ifdef FIFO_RD_STREAM_BEAT_CNT_EN
    ,
    parameter int unsigned CNT_WIDTH  = 32
`endif
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst_n,
    output logic                  fifo_rd_en,
    input  logic                  fifo_rd_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    fifo_rd_stream_if.master      m
`ifdef FIFO_RD_STREAM_BEAT_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0]  beat_cnt
`endif
);

    localparam pkt_idx_t LAST_IDX = pkt_idx_t'(PKT_LEN - 1);

    logic                  infl;
    logic                  pop;
    occ_t                  occ;
    logic [DATA_WIDTH-1:0] head;
    pkt_idx_t              beat_idx;

    assign pop        = m.m_valid & m.m_ready;
    assign fifo_rd_en = ~fifo_rd_empty & (pending(occ, infl, pop) < 3'd2);

    assign m.m_valid  = (occ != '0);
    assign m.m_data   = head;
    assign m.m_last   = m.m_valid & (beat_idx == LAST_IDX);

    // A read issued this cycle returns data on the next one.
    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            infl <= 1'b0;
        end else begin
            infl <= fifo_rd_en;
        end
    end

    // Position of the head word within its packet.
    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            beat_idx <= '0;
        end else if (pop) begin
            beat_idx <= (beat_idx == LAST_IDX) ? '0 : beat_idx + pkt_idx_t'(1);
        end
    end

`ifdef FIFO_RD_STREAM_BEAT_CNT_EN
    // Free-running count of accepted beats.
    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            beat_cnt <= '0;
        end else if (pop) begin
            beat_cnt <= beat_cnt + CNT_WIDTH'(1);
        end
    end
`endif

    fifo_rd_stream_skid #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk       (rd_clk),
        .rst_n     (rd_rst_n),
        .push      (infl),
        .push_data (fifo_rd_data),
        .pop       (pop),
        .occ       (occ),
        .head      (head)
    );

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: behavioural FIFO plus an order/framing scoreboard.
module tb_fifo_rd_stream;

    localparam int unsigned DW      = 32;
    localparam int unsigned PKT_LEN = 16;
`ifdef FIFO_RD_STREAM_BEAT_CNT_EN
    localparam int unsigned CNT_WIDTH = 32;
`endif

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b0;
    logic          fifo_rd_en;
    logic          rd_empty = 1'b1;
    logic [DW-1:0] rd_data  = '0;
    logic          wr_en    = 1'b0;
    logic [DW-1:0] wr_data  = '0;
`ifdef FIFO_RD_STREAM_BEAT_CNT_EN
    logic [CNT_WIDTH-1:0] beat_cnt;
`endif

    fifo_rd_stream_if #(.DATA_WIDTH(DW)) s_if ();

    fifo_rd_stream #(
        .DATA_WIDTH (DW),
        .PKT_LEN    (PKT_LEN)
`ifdef FIFO_RD_STREAM_BEAT_CNT_EN
        ,
        .CNT_WIDTH  (CNT_WIDTH)
`endif
    ) dut (
        .rd_clk        (clk),
        .rd_rst_n      (rst_n),
        .fifo_rd_en    (fifo_rd_en),
        .fifo_rd_empty (rd_empty),
        .fifo_rd_data  (rd_data),
        .m             (s_if.master)
`ifdef FIFO_RD_STREAM_BEAT_CNT_EN
        ,
        .beat_cnt      (beat_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural single-clock FIFO: one-cycle read latency, data held between reads.
    logic [DW-1:0] fq[$];
    logic [DW-1:0] exp_q[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fq.delete();
            exp_q.delete();
            rd_empty <= 1'b1;
            rd_data  <= '0;
        end else begin
            if (fifo_rd_en && fq.size() != 0) begin
                rd_data <= fq.pop_front();
            end
            if (wr_en) begin
                fq.push_back(wr_data);
                exp_q.push_back(wr_data);
            end
            rd_empty <= (fq.size() == 0);
        end
    end

    // Scoreboard: every accepted beat is the next written word; framing by beat number.
    int sb_beats = 0;
    int sb_reads = 0;
    int sb_lasts = 0;

    always @(negedge clk) begin
        #2;
        if (!rst_n) begin
            sb_beats = 0;
            sb_reads = 0;
            sb_lasts = 0;
        end else begin
            chk("no_underflow", 64'(fifo_rd_en & rd_empty), 64'(0));
            chk("outstanding_le2", 64'((sb_reads - sb_beats) <= 2), 64'(1));
            chk("m_last", 64'(s_if.m_last),
                64'(s_if.m_valid && ((sb_beats % PKT_LEN) == PKT_LEN - 1)));
`ifdef FIFO_RD_STREAM_BEAT_CNT_EN
            chk("beat_cnt", 64'(beat_cnt), 64'(CNT_WIDTH'(sb_beats)));
`endif
            if (fifo_rd_en) sb_reads++;
            if (s_if.m_valid && s_if.m_ready) begin
                chk("pop_has_data", 64'(exp_q.size() != 0), 64'(1));
                if (exp_q.size() != 0) begin
                    chk("m_data", 64'(s_if.m_data), 64'(exp_q.pop_front()));
                end
                if (s_if.m_last) sb_lasts++;
                sb_beats++;
            end
        end
    end

    typedef struct {
        logic          wr;
        logic [DW-1:0] d;
        logic          rdy;
        logic          e_rd_en;
        logic          e_valid;
        logic [DW-1:0] e_data;
        logic          e_last;
    } vec_t;

    vec_t vt[14];

    task automatic cyc(input logic w, input logic [DW-1:0] d, input logic r);
        @(negedge clk);
        wr_en       = w;
        wr_data     = d;
        s_if.m_ready = r;
        #2;
    endtask

    task automatic do_reset();
        @(negedge clk);
        wr_en        = 1'b0;
        s_if.m_ready = 1'b0;
        rst_n        = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int gaps, pops, lasts0, beats0, wrote, gap_valid;
        logic first;
        logic [DW-1:0] first_data;

        // latency, 2-deep fill under backpressure, resume without bubbles
        vt[0]  = '{1'b1, 32'h10, 1'b1, 1'b0, 1'b0, 32'h0,  1'b0};
        vt[1]  = '{1'b1, 32'h11, 1'b1, 1'b1, 1'b0, 32'h0,  1'b0};
        vt[2]  = '{1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 32'h0,  1'b0};
        vt[3]  = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 32'h10, 1'b0};
        vt[4]  = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 32'h11, 1'b0};
        vt[5]  = '{1'b1, 32'h20, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0};
        vt[6]  = '{1'b1, 32'h21, 1'b0, 1'b1, 1'b0, 32'h0,  1'b0};
        vt[7]  = '{1'b1, 32'h22, 1'b0, 1'b1, 1'b0, 32'h0,  1'b0};
        vt[8]  = '{1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 32'h20, 1'b0};
        vt[9]  = '{1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 32'h20, 1'b0};
        vt[10] = '{1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 32'h20, 1'b0};
        vt[11] = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 32'h21, 1'b0};
        vt[12] = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 32'h22, 1'b0};
        vt[13] = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 32'h0,  1'b0};

        s_if.m_ready = 1'b1;

        // Reset held while a writer is active
        repeat (3) cyc(1'b1, 32'h55, 1'b1);
        chk("rst_rd_en", 64'(fifo_rd_en), 64'(0));
        chk("rst_valid", 64'(s_if.m_valid), 64'(0));
        chk("rst_last", 64'(s_if.m_last), 64'(0));
        chk("rst_data", 64'(s_if.m_data), 64'(0));
`ifdef FIFO_RD_STREAM_BEAT_CNT_EN
        chk("rst_beat_cnt", 64'(beat_cnt), 64'(0));
`endif
        @(negedge clk);
        rst_n = 1'b1; wr_en = 1'b1; wr_data = 32'h100; s_if.m_ready = 1'b1;
        #2;
        chk("rel_rd_en_before", 64'(fifo_rd_en), 64'(0));
        cyc(1'b0, '0, 1'b1);
        chk("rel_rd_en_n", 64'(fifo_rd_en), 64'(1));
        chk("rel_valid_n", 64'(s_if.m_valid), 64'(0));
        cyc(1'b0, '0, 1'b1);
        chk("rel_valid_n1", 64'(s_if.m_valid), 64'(0));
        cyc(1'b0, '0, 1'b1);
        chk("rel_valid_n2", 64'(s_if.m_valid), 64'(1));
        chk("rel_data_n2", 64'(s_if.m_data), 64'(32'h100));
        cyc(1'b0, '0, 1'b1);

        // Table vectors
        do_reset();
        for (int i = 0; i < 14; i++) begin
            cyc(vt[i].wr, vt[i].d, vt[i].rdy);
            chk($sformatf("vec%0d_rd_en", i), 64'(fifo_rd_en), 64'(vt[i].e_rd_en));
            chk($sformatf("vec%0d_valid", i), 64'(s_if.m_valid), 64'(vt[i].e_valid));
            if (vt[i].e_valid) begin
                chk($sformatf("vec%0d_data", i), 64'(s_if.m_data), 64'(vt[i].e_data));
            end
            chk($sformatf("vec%0d_last", i), 64'(s_if.m_last), 64'(vt[i].e_last));
        end

        // Streaming 0..63
        do_reset();
        lasts0 = sb_lasts; gaps = 0; pops = 0; first = 1'b0;
        for (int c = 0; c < 200 && pops < 64; c++) begin
            cyc(logic'(c < 64), DW'(c), 1'b1);
            if (s_if.m_valid) begin
                first = 1'b1;
                pops++;
            end else if (first) begin
                gaps++;
            end
        end
        cyc(1'b0, '0, 1'b1);
        chk("stream_pops", 64'(pops), 64'(64));
        chk("stream_gaps", 64'(gaps), 64'(0));
        chk("stream_lasts", 64'(sb_lasts - lasts0), 64'(4));
`ifdef FIFO_RD_STREAM_BEAT_CNT_EN
        chk("stream_beat_cnt", 64'(beat_cnt), 64'(64));
`endif

        // Partial packet: 10 words, idle gap, 6 words
        lasts0 = sb_lasts; gap_valid = 0;
        for (int i = 0; i < 10; i++) cyc(1'b1, DW'(32'h200 + i), 1'b1);
        for (int c = 0; c < 20; c++) begin
            cyc(1'b0, '0, 1'b1);
            if (c >= 5 && s_if.m_valid) gap_valid++;
        end
        chk("partial_gap_valid", 64'(gap_valid), 64'(0));
        chk("partial_no_early_last", 64'(sb_lasts - lasts0), 64'(0));
        for (int i = 10; i < 16; i++) cyc(1'b1, DW'(32'h200 + i), 1'b1);
        repeat (8) cyc(1'b0, '0, 1'b1);
        chk("partial_lasts", 64'(sb_lasts - lasts0), 64'(1));

        // Random interleave
        beats0 = sb_beats; wrote = 0;
        for (int c = 0; c < 20000 && wrote < 1000; c++) begin
            logic w;
            w = logic'($urandom_range(0, 1));
            cyc(w, DW'($urandom), logic'($urandom_range(0, 1)));
            if (w) wrote++;
        end
        chk("rand_wrote", 64'(wrote), 64'(1000));
        for (int c = 0; c < 3000 && exp_q.size() != 0; c++) cyc(1'b0, '0, 1'b1);
        repeat (3) cyc(1'b0, '0, 1'b1);
        chk("rand_drained", 64'(exp_q.size()), 64'(0));
        chk("rand_beats", 64'(sb_beats - beats0), 64'(1000));

        // Reset while the buffer is full
        cyc(1'b1, 32'h300, 1'b0);
        cyc(1'b1, 32'h301, 1'b0);
        cyc(1'b1, 32'h302, 1'b0);
        cyc(1'b0, '0, 1'b0);
        cyc(1'b0, '0, 1'b0);
        chk("pre_rst_valid", 64'(s_if.m_valid), 64'(1));
        chk("pre_rst_data", 64'(s_if.m_data), 64'(32'h300));
        chk("pre_rst_rd_en", 64'(fifo_rd_en), 64'(0));
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(s_if.m_valid), 64'(0));
        chk("mid_rst_last", 64'(s_if.m_last), 64'(0));
        chk("mid_rst_data", 64'(s_if.m_data), 64'(0));
        chk("mid_rst_rd_en", 64'(fifo_rd_en), 64'(0));
`ifdef FIFO_RD_STREAM_BEAT_CNT_EN
        chk("mid_rst_beat_cnt", 64'(beat_cnt), 64'(0));
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        lasts0 = sb_lasts; first = 1'b0; first_data = '0; pops = 0;
        for (int c = 0; c < 40; c++) begin
            cyc(logic'(c < 16), DW'(32'hA5A5_0000 + c), 1'b1);
            if (s_if.m_valid) begin
                if (!first) first_data = s_if.m_data;
                first = 1'b1;
                pops++;
            end
        end
        cyc(1'b0, '0, 1'b1);
        chk("refill_first", 64'(first_data), 64'(32'hA5A5_0000));
        chk("refill_pops", 64'(pops), 64'(16));
        chk("refill_lasts", 64'(sb_lasts - lasts0), 64'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
